// File: rtl/radix4_booth_seq_mul.sv
// ---------------------------------------------------------------------------
// radix4_booth_seq_mul
//
// Iterative unsigned multiplier. It accepts a WIDTH x WIDTH operand pair,
// radix-4 Booth recodes the multiplier b one digit per clock, and accumulates
// the generator's gen/sign partial products into a 2*WIDTH-bit product.
// It is the area-light alternative to a combinational Booth tree.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair on a/b is valid
//   in_ready   block can accept an operand pair (IDLE only)
//   a          unsigned multiplicand, WIDTH bits
//   b          unsigned multiplier (Booth-recoded), WIDTH bits
//   out_valid  product is valid (DONE)
//   out_ready  consumer accepts the product
//   product    unsigned a*b, 2*WIDTH bits
//   busy       high in RUN or DONE
// ---------------------------------------------------------------------------

// Unsigned radix-4 Booth partial-product generator.
// Value of the partial product is gen + sign - sign*2^(WIDTH+1):
// negative multiples are emitted as their one's complement with sign=1,
// so the +1 of the two's complement is folded in by the consumer.
module radix4_booth_pp_gen #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [2:0]       digit,
    output logic [WIDTH:0]   gen,
    output logic             sign
);
    always_comb begin
        // NOTE: default every combinational output first so no path through
        // the case statement can leave it unassigned and infer a latch.
        gen  = '0;
        sign = 1'b0;
        unique case (digit)
            3'b001, 3'b010: gen = {1'b0, a};
            3'b011:         gen = {a, 1'b0};
            3'b100: begin
                gen  = ~{a, 1'b0};
                sign = 1'b1;
            end
            3'b101, 3'b110: begin
                gen  = ~{1'b0, a};
                sign = 1'b1;
            end
            default: ;  // 000 and 111 contribute zero
        endcase
    end
endmodule

module radix4_booth_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int N   = WIDTH / 2 + 1;          // number of Booth digits
    localparam int KW  = $clog2(N);              // digit index width
    localparam int AW  = 2 * WIDTH + 2;          // accumulator width
    localparam int PW  = WIDTH + 2;              // signed partial-product width
    // Padded multiplier is wide enough that every encodable k selects in range.
    localparam int BPW = 2 * (2 ** KW) + 2;

    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [AW-1:0]      acc;
    logic [KW-1:0]      k;
    logic [2*WIDTH-1:0] product_r;

    logic [BPW-1:0]     b_pad;
    logic [2:0]         digit;
    logic [WIDTH:0]     gen;
    logic               sign;
    logic [PW-1:0]      pp;
    logic [AW-1:0]      pp_wide;
    logic [AW-1:0]      acc_next;

    // B' = {.., 2'b00, b_r, 1'b0}: the trailing zero is the implicit b[-1].
    assign b_pad = BPW'({b_r, 1'b0});
    assign digit = b_pad[{k, 1'b0} +: 3];

    radix4_booth_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
        .a     (a_r),
        .digit (digit),
        .gen   (gen),
        .sign  (sign)
    );

    // {sign, gen} read as two's complement is gen - sign*2^(WIDTH+1);
    // adding sign completes the negation of the one's-complement multiple.
    assign pp       = {sign, gen} + PW'(sign);
    assign pp_wide  = {{(AW - PW){pp[PW-1]}}, pp};
    assign acc_next = acc + (pp_wide << {k, 1'b0});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            k         <= '0;
            product_r <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        acc   <= '0;
                        k     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    k   <= k + 1'b1;
                    if (k == K_LAST) begin
                        // Final sum is exact and fits 2*WIDTH bits.
                        product_r <= acc_next[2*WIDTH-1:0];
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // in_ready is forced low while reset is asserted even though the state
    // register already reads IDLE.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign product   = product_r;

endmodule

// File: tb/tb_radix4_booth_seq_mul.sv
// ---------------------------------------------------------------------------
// tb_radix4_booth_seq_mul
//
// Directed checks on a WIDTH=8 instance (latency, busy span, back-pressure,
// mid-run reset) followed by randomized back-to-back traffic on WIDTH=7, 8
// and 16 instances with random out_ready. Expected products come from plain
// a*b arithmetic held in per-instance queues.
// ---------------------------------------------------------------------------
module tb_radix4_booth_seq_mul;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid    [3];
    logic        out_ready   [3];
    logic [15:0] a_v         [3];
    logic [15:0] b_v         [3];
    logic        in_ready_s  [3];
    logic        out_valid_s [3];
    logic        busy_s      [3];
    logic [13:0] p7;
    logic [15:0] p8;
    logic [31:0] p16;

    int n_checks = 0;
    int n_pass   = 0;

    radix4_booth_seq_mul #(.WIDTH(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_s[0]),
        .a(a_v[0][6:0]), .b(b_v[0][6:0]), .out_valid(out_valid_s[0]),
        .out_ready(out_ready[0]), .product(p7), .busy(busy_s[0])
    );
    radix4_booth_seq_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_s[1]),
        .a(a_v[1][7:0]), .b(b_v[1][7:0]), .out_valid(out_valid_s[1]),
        .out_ready(out_ready[1]), .product(p8), .busy(busy_s[1])
    );
    radix4_booth_seq_mul #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready_s[2]),
        .a(a_v[2]), .b(b_v[2]), .out_valid(out_valid_s[2]),
        .out_ready(out_ready[2]), .product(p16), .busy(busy_s[2])
    );

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [31:0] exp_q2[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] prod_of(input int d);
        case (d)
            0:       return 32'(p7);
            1:       return 32'(p8);
            default: return p16;
        endcase
    endfunction

    function automatic logic [15:0] pick(input int w);
        logic [15:0] m = 16'((32'h1 << w) - 1);
        case ($urandom_range(0, 7))
            0:       return 16'h0;
            1:       return m;
            2:       return 16'h1;
            3:       return 16'(32'h1 << (w - 1));
            default: return 16'($urandom) & m;
        endcase
    endfunction

    task automatic push_exp(input int d, input logic [31:0] v);
        case (d)
            0:       exp_q0.push_back(v);
            1:       exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endtask

    task automatic pop_check(input int d);
        logic [31:0] e;
        int sz;
        case (d)
            0:       sz = exp_q0.size();
            1:       sz = exp_q1.size();
            default: sz = exp_q2.size();
        endcase
        if (sz == 0) begin
            check($sformatf("unexpected_out_d%0d", d), 64'(1), 64'(0));
        end else begin
            case (d)
                0:       e = exp_q0.pop_front();
                1:       e = exp_q1.pop_front();
                default: e = exp_q2.pop_front();
            endcase
            check($sformatf("rand_prod_d%0d", d), 64'(prod_of(d)), 64'(e));
        end
    endtask

    // One WIDTH=8 transaction. hold = number of stall cycles with out_ready=0
    // after out_valid rises; in_valid is driven during the stall to show it is
    // ignored outside IDLE.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input int hold,
                        output logic [15:0] prod, output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        prod = 'x;
        @(negedge clk);
        check("in_ready_before_accept", 64'(in_ready_s[1]), 64'(1));
        in_valid[1]  = 1'b1;
        a_v[1]       = {8'h0, ta};
        b_v[1]       = {8'h0, tb_v};
        out_ready[1] = (hold == 0);
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                in_valid[1] = 1'b0;
                a_v[1]      = 16'($urandom) & 16'h00FF;
                b_v[1]      = 16'($urandom) & 16'h00FF;
            end
            if (busy_s[1]) bcnt++;
            if (out_valid_s[1]) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            check("out_valid_timeout", 64'(0), 64'(1));
            return;
        end
        prod = p8;
        for (int h = 0; h < hold; h++) begin
            in_valid[1] = 1'b1;
            a_v[1]      = 16'h0011;
            b_v[1]      = 16'h0022;
            @(negedge clk);
            check("hold_out_valid", 64'(out_valid_s[1]), 64'(1));
            check("hold_product",   64'(p8),             64'(prod));
            check("hold_in_ready",  64'(in_ready_s[1]),  64'(0));
        end
        out_ready[1] = 1'b1;
        @(negedge clk);
        in_valid[1] = 1'b0;
        check("post_out_valid", 64'(out_valid_s[1]), 64'(0));
        check("post_in_ready",  64'(in_ready_s[1]),  64'(1));
        check("post_busy",      64'(busy_s[1]),      64'(0));
        if (hold > 0) begin
            @(negedge clk);
            check("ignored_in_valid_busy", 64'(busy_s[1]), 64'(0));
        end
    endtask

    initial begin
        logic [15:0] prod;
        int          lat;
        int          bcnt;
        int          done_cnt [3];
        int          widths   [3];
        logic [31:0] e;

        widths = '{7, 8, 16};
        rst_n  = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            a_v[d]       = '0;
            b_v[d]       = '0;
            done_cnt[d]  = 0;
        end

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_in_ready",  64'(in_ready_s[1]),  64'(0));
        check("rst_out_valid", 64'(out_valid_s[1]), 64'(0));
        check("rst_busy",      64'(busy_s[1]),      64'(0));
        check("rst_product",   64'(p8),             64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready_s[1]), 64'(1));

        // Directed products.
        run8(8'hFF, 8'hFF, 0, prod, lat, bcnt);
        check("ff_ff_product", 64'(prod), 64'(16'hFE01));
        check("ff_ff_latency", 64'(lat),  64'(5));
        check("ff_ff_busy",    64'(bcnt), 64'(6));
        run8(8'hAA, 8'h55, 0, prod, lat, bcnt);
        check("aa_55_product", 64'(prod), 64'(16'h3872));
        run8(8'h01, 8'h80, 0, prod, lat, bcnt);
        check("01_80_product", 64'(prod), 64'(16'h0080));
        run8(8'h00, 8'hFF, 0, prod, lat, bcnt);
        check("00_ff_product", 64'(prod), 64'(16'h0000));
        run8(8'hFF, 8'hCC, 0, prod, lat, bcnt);
        check("ff_cc_product", 64'(prod), 64'(16'hCB34));

        // Back-pressure for 3 cycles.
        run8(8'h12, 8'h34, 3, prod, lat, bcnt);
        check("bp_product", 64'(prod), 64'(16'h03A8));
        check("bp_latency", 64'(lat),  64'(5));

        // Reset asserted in the third RUN cycle.
        @(negedge clk);
        in_valid[1]  = 1'b1;
        a_v[1]       = 16'h00FF;
        b_v[1]       = 16'h00FF;
        out_ready[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_busy", 64'(busy_s[1]), 64'(1));
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid_s[1]), 64'(0));
        check("midrst_busy",      64'(busy_s[1]),      64'(0));
        check("midrst_product",   64'(p8),             64'(0));
        check("midrst_in_ready",  64'(in_ready_s[1]),  64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run8(8'd3, 8'd7, 0, prod, lat, bcnt);
        check("after_rst_product", 64'(prod), 64'(21));
        check("after_rst_latency", 64'(lat),  64'(5));

        // Randomized back-to-back traffic on all three widths; the last
        // 80 cycles drain with in_valid low and out_ready high.
        for (int cyc = 0; cyc < 24080; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (cyc < 24000) begin
                    in_valid[d]  = ($urandom_range(0, 3) != 0);
                    out_ready[d] = ($urandom_range(0, 2) != 0);
                end else begin
                    in_valid[d]  = 1'b0;
                    out_ready[d] = 1'b1;
                end
                a_v[d] = pick(widths[d]);
                b_v[d] = pick(widths[d]);
                if (in_valid[d] && in_ready_s[d]) begin
                    e = 32'(a_v[d]) * 32'(b_v[d]);
                    push_exp(d, e);
                end
                if (out_valid_s[d] && out_ready[d]) begin
                    pop_check(d);
                    done_cnt[d]++;
                end
            end
        end
        check("drain_q_w7",  64'(exp_q0.size()), 64'(0));
        check("drain_q_w8",  64'(exp_q1.size()), 64'(0));
        check("drain_q_w16", 64'(exp_q2.size()), 64'(0));
        check("progress_w7",  64'(done_cnt[0] > 1000), 64'(1));
        check("progress_w8",  64'(done_cnt[1] > 1000), 64'(1));
        check("progress_w16", 64'(done_cnt[2] > 1000), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
